// File: rtl/config_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : config_chain_loader                                        |
// | Description : Clears a D flip-flop configuration scan chain, then shifts |
// |               in a word-delivered bitstream LSB first, one bit per       |
// |               enabled cycle, with busy/done status and a sticky error.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module config_chain_loader #(
  parameter int CHAIN_LEN  = 64,
  parameter int WORD_W     = 8,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              sc_head,
  output logic              sc_en,
  output logic              sc_clr_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int c_BL_W = $clog2(CHAIN_LEN + 1);
  localparam int c_WB_W = $clog2(WORD_W + 1);
  localparam int c_CC_W = $clog2(CLR_CYCLES + 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLEAR = 3'd1;
  localparam logic [2:0] c_LOAD  = 3'd2;
  localparam logic [2:0] c_SHIFT = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [c_BL_W-1:0] c_CHAIN_LEN  = c_BL_W'(CHAIN_LEN);
  localparam logic [c_WB_W-1:0] c_WORD_W     = c_WB_W'(WORD_W);
  localparam logic [c_CC_W-1:0] c_CLR_CYCLES = c_CC_W'(CLR_CYCLES);
  localparam logic [c_BL_W-1:0] c_BL_ONE     = c_BL_W'(1);
  localparam logic [c_WB_W-1:0] c_WB_ONE     = c_WB_W'(1);
  localparam logic [c_CC_W-1:0] c_CC_ONE     = c_CC_W'(1);

  logic [2:0]        r_state;
  logic [c_BL_W-1:0] r_bits_left;
  logic [c_WB_W-1:0] r_word_bits;
  logic [c_CC_W-1:0] r_clr_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic              r_err;

  logic              w_busy;
  logic              w_bits_lt_word;
  logic [c_WB_W-1:0] w_word_bits_init;

  // When fewer than WORD_W bits remain, bits_left is below WORD_W and so
  // fits in the word_bits counter; the upper word bits are simply never shifted.
  assign w_bits_lt_word   = (32'(r_bits_left) < 32'(WORD_W));
  assign w_word_bits_init = w_bits_lt_word ? c_WB_W'(r_bits_left) : c_WORD_W;

  // Status and chain-side outputs decode straight from state; abort
  // suppresses both the word handshake and the shift in its cycle.
  assign w_busy     = (r_state == c_CLEAR) || (r_state == c_LOAD) || (r_state == c_SHIFT);
  assign busy       = w_busy;
  assign done       = (r_state == c_DONE);
  assign err        = r_err;
  assign word_ready = (r_state == c_LOAD) && !abort;
  assign sc_en      = (r_state == c_SHIFT) && !abort;
  assign sc_head    = sc_en & r_shreg[0];
  assign sc_clr_n   = (r_state != c_CLEAR);

  // Load sequencer: clear hold, word capture, bit shifting, abort and error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_bits_left <= '0;
      r_word_bits <= '0;
      r_clr_cnt   <= '0;
      r_shreg     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (start && w_busy) begin
        r_err <= 1'b1;
      end else if (start) begin
        r_err <= 1'b0;
      end

      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_state     <= c_CLEAR;
            r_bits_left <= c_CHAIN_LEN;
            r_clr_cnt   <= c_CLR_CYCLES;
          end
        end
        c_CLEAR: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else if (r_clr_cnt > c_CC_ONE) begin
            r_clr_cnt <= r_clr_cnt - c_CC_ONE;
          end else begin
            r_clr_cnt <= '0;
            r_state   <= c_LOAD;
          end
        end
        c_LOAD: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else if (word_valid) begin
            r_shreg     <= word_data;
            r_word_bits <= w_word_bits_init;
            r_state     <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          if (abort) begin
            r_state <= c_IDLE;
          end else begin
            r_shreg <= r_shreg >> 1;
            if (r_word_bits != '0) r_word_bits <= r_word_bits - c_WB_ONE;
            if (r_bits_left != '0) r_bits_left <= r_bits_left - c_BL_ONE;
            if (r_word_bits <= c_WB_ONE) begin
              r_state <= (r_bits_left <= c_BL_ONE) ? c_DONE : c_LOAD;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_config_chain_loader                                     |
// | Description : Self-checking bench for config_chain_loader; a 12-bit      |
// |               chain instance and a 1-bit chain instance.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_config_chain_loader;

  localparam int CL = 12;
  localparam int WW = 8;
  localparam int CC = 2;

  logic clk = 1'b0;
  logic reset;

  logic       start, abort, word_valid;
  logic [7:0] word_data;
  logic       word_ready, sc_head, sc_en, sc_clr_n, busy, done, err;

  logic       start1, abort1, word_valid1;
  logic [7:0] word_data1;
  logic       word_ready1, sc_head1, sc_en1, sc_clr_n1, busy1, done1, err1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] words[$];
  int         gaps[$];
  logic       got[$];
  int         en_cnt, clr_cnt, busy_cnt, hold_cnt;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLR_CYCLES(CC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .sc_head(sc_head), .sc_en(sc_en), .sc_clr_n(sc_clr_n),
    .busy(busy), .done(done), .err(err)
  );

  config_chain_loader #(.CHAIN_LEN(1), .WORD_W(WW), .CLR_CYCLES(CC)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .word_data(word_data1), .word_valid(word_valid1), .word_ready(word_ready1),
    .sc_head(sc_head1), .sc_en(sc_en1), .sc_clr_n(sc_clr_n1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_sum();
    int s = 0;
    foreach (gaps[i]) s += gaps[i];
    return s;
  endfunction

  // mode 0: plain load, 1: start pulse after 3rd shifted bit,
  // 2: reset after 3rd shifted bit, 3: abort in first LOAD cycle
  task automatic run_load(input int mode);
    int idx = 0;
    int gcnt;
    got.delete();
    en_cnt = 0; clr_cnt = 0; busy_cnt = 0; hold_cnt = 0;
    gcnt = gaps[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      word_valid = (idx < words.size()) && (gcnt == 0);
      word_data  = (idx < words.size()) ? words[idx] : 8'h00;
      if (mode == 3 && clr_cnt == CC) begin
        abort = 1'b1;
        word_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, word_ready}, 32'd0);
        chk("abort_en", {31'd0, sc_en}, 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        word_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_clr_n", {31'd0, sc_clr_n}, 32'd1);
        return;
      end
      @(negedge clk);
      if (sc_en) begin
        got.push_back(sc_head);
        en_cnt++;
      end else if (sc_head !== 1'b0) begin
        chk("head_idle", {31'd0, sc_head}, 32'd0);
      end
      if (!sc_clr_n) clr_cnt++;
      if (busy) busy_cnt++;
      if (busy && sc_clr_n && !sc_en && !word_ready)
        chk("load_ready", {31'd0, word_ready}, 32'd1);
      if (word_ready && !word_valid) hold_cnt++;
      if (word_valid && word_ready) begin
        idx++;
        gcnt = (idx < gaps.size()) ? gaps[idx] : 0;
      end else if (word_ready && gcnt > 0) begin
        gcnt--;
      end
      if (done) begin
        word_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (mode == 1 && sc_en && en_cnt == 3) start = 1'b1;
      if (mode == 2 && sc_en && en_cnt == 3) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        word_valid = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, sc_en}, 32'd0);
        chk("rst_clr_n", {31'd0, sc_clr_n}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, word_ready}, 32'd0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("timeout", {31'd0, done}, 32'd1);
  endtask

  // Expected chain content: word bits concatenated LSB first, truncated to CL.
  task automatic check_result(input string tag);
    logic [7:0] w;
    chk({tag, "_clr_cycles"}, clr_cnt, CC);
    chk({tag, "_en_cycles"}, en_cnt, CL);
    chk({tag, "_hold"}, hold_cnt, gap_sum());
    chk({tag, "_busy_cycles"}, busy_cnt, CC + words.size() + CL + gap_sum());
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    for (int i = 0; i < CL; i++) begin
      w = words[i / WW];
      chk($sformatf("%s_bit%0d", tag, i),
          {31'd0, (i < got.size()) ? got[i] : 1'bx}, {31'd0, w[i % WW]});
    end
  endtask

  initial begin
    int en1;
    logic h1;
    logic [7:0] rw;
    reset = 1'b1;
    start = 0; abort = 0; word_valid = 0; word_data = 0;
    start1 = 0; abort1 = 0; word_valid1 = 0; word_data1 = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_word_ready", {31'd0, word_ready}, 32'd0);
    chk("rst_sc_head", {31'd0, sc_head}, 32'd0);
    chk("rst_sc_en", {31'd0, sc_en}, 32'd0);
    chk("rst_sc_clr_n", {31'd0, sc_clr_n}, 32'd1);
    chk("rst_busy0", {31'd0, busy}, 32'd0);
    chk("rst_done0", {31'd0, done}, 32'd0);
    chk("rst_err0", {31'd0, err}, 32'd0);

    // Directed: A5 then 3C, source always valid
    words = {8'hA5, 8'h3C};
    gaps  = {0, 0};
    run_load(0);
    check_result("dir");

    // Five idle LOAD cycles before the second word
    gaps = {0, 5};
    run_load(0);
    check_result("gap");

    // start during SHIFT sets err, sequence unaffected
    words = {8'($urandom), 8'($urandom)};
    gaps  = {0, 0};
    run_load(1);
    check_result("errpulse");
    chk("err_sticky", {31'd0, err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held_done", {31'd0, err}, 32'd1);
    run_load(0);
    check_result("after_err");

    // Abort in LOAD with a valid word, then full replay
    run_load(3);
    words = {8'($urandom), 8'($urandom)};
    run_load(0);
    check_result("replay");

    // Reset mid-SHIFT, then a clean load
    run_load(2);
    run_load(0);
    check_result("post_rst");

    // Randomized words and source gaps
    for (int r = 0; r < 6; r++) begin
      words = {8'($urandom), 8'($urandom)};
      gaps  = {int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
      run_load(0);
      check_result($sformatf("rnd%0d", r));
    end

    // One-bit chain: 0xFE shifts a single 0, then a random word's bit 0
    for (int k = 0; k < 2; k++) begin
      rw = (k == 0) ? 8'hFE : 8'($urandom);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      word_valid1 = 1'b1;
      word_data1  = rw;
      en1 = 0;
      h1  = 1'bx;
      for (int c = 0; c < 20 && !done1; c++) begin
        @(negedge clk);
        if (sc_en1) begin
          en1++;
          h1 = sc_head1;
        end
        @(posedge clk); #1;
      end
      word_valid1 = 1'b0;
      chk($sformatf("len1_en_%0d", k), en1, 1);
      chk($sformatf("len1_head_%0d", k), {31'd0, h1}, {31'd0, rw[0]});
      chk($sformatf("len1_done_%0d", k), {31'd0, done1}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
